// File: rtl/vote_capture.sv
// Voter button front-end: synchronizes and debounces three raw buttons, then
// latches votes over a fixed-length window and presents them frozen with valid.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no round in progress, outputs zero, waiting for start
// COLLECT | window open; debounced presses latch into sticky vote bits
// HOLD    | window closed; votes frozen on v1..v3 with valid high
module vote_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WINDOW_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic v1,
  output logic v2,
  output logic v3,
  output logic valid,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [7:0]  DB_MAX   = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] WIN_LOAD = 16'(WINDOW_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] win_cnt, win_next;
  logic [2:0]  b_raw;
  logic [2:0]  sync1, sync2;
  logic [2:0]  d;
  logic [2:0]  p, p_next;
  logic [2:0]  v_q, v_next;

  assign b_raw = {b3, b2, b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= b_raw;
      sync2 <= sync1;
    end
  end

  // Per-channel saturating debounce; any low sample restarts the count.
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
      if (rst)
        cnt <= '0;
      else if (!sync2[i])
        cnt <= '0;
      else if (cnt != DB_MAX)
        cnt <= cnt + 8'd1;
    end

    assign d[i] = (cnt == DB_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      win_cnt <= '0;
      p       <= '0;
      v_q     <= '0;
    end else begin
      state   <= state_next;
      win_cnt <= win_next;
      p       <= p_next;
      v_q     <= v_next;
    end
  end

  always_comb begin
    state_next = state;
    win_next   = win_cnt;
    p_next     = p;
    v_next     = v_q;
    unique case (state)
      IDLE: begin
        v_next = '0;
        if (start) begin
          state_next = COLLECT;
          win_next   = WIN_LOAD;
          p_next     = '0;
        end
      end
      COLLECT: begin
        p_next = p | d;
        v_next = '0;
        if (win_cnt == 16'd0) begin
          // The final window edge still samples d, so the frozen votes
          // must include it rather than the registered p.
          state_next = HOLD;
          v_next     = p | d;
        end else begin
          win_next = win_cnt - 16'd1;
        end
      end
      HOLD: begin
        if (start) begin
          state_next = COLLECT;
          win_next   = WIN_LOAD;
          p_next     = '0;
          v_next     = '0;
        end
      end
      default: begin
        state_next = IDLE;
        win_next   = '0;
        p_next     = '0;
        v_next     = '0;
      end
    endcase
  end

  assign busy  = (state == COLLECT);
  assign valid = (state == HOLD);
  assign v1    = v_q[0];
  assign v2    = v_q[1];
  assign v3    = v_q[2];

endmodule

// File: tb/tb_vote_capture.sv
// Self-checking bench for vote_capture: expected vote words are queued when a
// round is started and compared when valid rises.
module tb_vote_capture;

  logic clk = 1'b0;
  logic rst, start, b1, b2, b3;
  logic v1, v2, v3, valid, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int busy_run  = 0;
  logic prev_busy  = 1'b0;
  logic prev_valid = 1'b0;
  logic mon_en  = 1'b0;
  logic aborted = 1'b0;
  logic [2:0] sb[$];

  vote_capture #(.DEBOUNCE_CYCLES(4), .WINDOW_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .b1(b1), .b2(b2), .b3(b3),
    .v1(v1), .v2(v2), .v3(v3),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_round(input logic [2:0] exp, input logic push);
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    if (push) sb.push_back(exp);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (valid !== 1'b1) chk("valid_timeout", 32'(valid), 1);
  endtask

  // Sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!valid) chk("v_without_valid", {v3, v2, v1}, 0);
      chk("valid_busy_excl", valid & busy, 0);
      if (valid && !prev_valid) begin
        chk("valid_latency", cyc - start_cyc, 16);
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("votes", {v3, v2, v1}, sb.pop_front());
      end
      if (busy) busy_run++;
      if (prev_busy && !busy) begin
        if (!aborted) chk("busy_len", busy_run, 16);
        busy_run = 0;
      end
      prev_busy  = busy;
      prev_valid = valid;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b1; b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
    ticks(3);
    chk("rst_over_start_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_votes", {v3, v2, v1}, 0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Idle with toggling buttons: nothing may move without start.
    for (int i = 0; i < 20; i++) begin
      b1 = 1'($urandom_range(0, 1));
      b2 = 1'($urandom_range(0, 1));
      b3 = 1'($urandom_range(0, 1));
      tick();
      chk("idle_outputs", {valid, busy, v3, v2, v1}, 0);
    end
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0;
    ticks(8);

    // Basic round: b1 and b3 pressed.
    start_round(3'b101, 1'b1);
    chk("busy_after_start", busy, 1);
    tick();
    b1 = 1'b1; b3 = 1'b1;
    wait_valid();
    b1 = 1'b0; b3 = 1'b0;
    b2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_valid", valid, 1);
      chk("hold_votes", {v3, v2, v1}, 3'b101);
    end

    // Restart from HOLD with b2 held: same-edge drop, then vote 010.
    start_round(3'b010, 1'b1);
    chk("restart_valid", valid, 0);
    chk("restart_votes", {v3, v2, v1}, 0);
    chk("restart_busy", busy, 1);
    wait_valid();
    b2 = 1'b0;
    ticks(8);

    // Bounce shorter than the debounce length never counts.
    start_round(3'b000, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      b2 = (i == 3 || i == 7) ? 1'b0 : 1'b1;
      tick();
    end
    b2 = 1'b0;
    wait_valid();

    // Four clean cycles do count.
    start_round(3'b010, 1'b1);
    tick();
    b2 = 1'b1;
    ticks(4);
    b2 = 1'b0;
    wait_valid();
    ticks(8);

    // d1 first asserts on the last COLLECT edge: counted.
    start_round(3'b001, 1'b1);
    ticks(9);
    b1 = 1'b1;
    wait_valid();
    b1 = 1'b0;
    ticks(8);

    // One cycle later it lands in HOLD: not counted, even while held.
    start_round(3'b000, 1'b1);
    ticks(10);
    b1 = 1'b1;
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("late_press_ignored", {v3, v2, v1}, 0);
    end
    b1 = 1'b0;
    ticks(8);

    // Reset mid-window with a vote already latched.
    start_round(3'b000, 1'b0);
    tick();
    b3 = 1'b1;
    ticks(10);
    aborted = 1'b1;
    rst = 1'b1;
    tick();
    chk("midrst_outputs", {valid, busy, v3, v2, v1}, 0);
    rst = 1'b0;
    b3 = 1'b0;
    ticks(8);
    chk("midrst_idle", {valid, busy}, 0);
    aborted = 1'b0;

    start_round(3'b000, 1'b1);
    wait_valid();
    ticks(3);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vote_capture.md
Name: vote_capture

Overview:
- Front-end for the three-input voting logic: turns three raw, bouncy, asynchronous voter buttons into clean, frame-latched vote bits v1/v2/v3.
- The downstream combinational voting stage consumes v1/v2/v3 directly.
- A start pulse opens a fixed-length voting window.
  - Any voter whose debounced input goes high during the window has its vote latched.
  - When the window closes, the votes are frozen and presented with valid.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized-high cycles required before an input counts as pressed; legal range 1..255.
- WINDOW_CYCLES, 16: length of the COLLECT window in clock cycles; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset: synchronous and active-high. It returns every register to its reset value at the next clk edge.
- start  input  1  synchronous request to begin a voting round; sampled each cycle.
- b1  input  1  raw button, voter 1; asynchronous and bouncy.
- b2  input  1  raw button, voter 2; asynchronous and bouncy.
- b3  input  1  raw button, voter 3; asynchronous and bouncy.
- v1  output  1  latched vote, voter 1; feeds the voting stage.
- v2  output  1  latched vote, voter 2.
- v3  output  1  latched vote, voter 3.
- valid  output  1  high while v1..v3 hold a completed round.
- busy  output  1  high while the window is open (state COLLECT).

Behaviour:
- Reset: state=IDLE, v1=v2=v3=0, valid=0, busy=0. Synchronizer flops, debounce counters and window counter are all cleared.
- Synchronizer:
  - Each bN passes through a 2-flop synchronizer, giving sN.
  - If bN is stable high before edge k, sN is high after edge k+1.
- Debounce, per channel:
  - 8-bit counter cN. If sN=1, cN increments, saturating at DEBOUNCE_CYCLES. If sN=0, cN is cleared to 0.
  - dN = (cN == DEBOUNCE_CYCLES).
  - A single low sample restarts the count.
  - Debounce runs in all states.
- Vote bits (internal):
  - Sticky: pN is set on any edge where state=COLLECT and dN=1.
  - Never cleared inside a round.
  - Cleared on entry to COLLECT.
- FSM:
  - IDLE:
    - start=1 -> COLLECT; load window counter = WINDOW_CYCLES-1 and clear p1..p3.
    - Otherwise stay.
  - COLLECT:
    - busy=1.
    - Counter decrements each cycle.
    - When counter==0, -> HOLD on that edge.
    - COLLECT therefore lasts exactly WINDOW_CYCLES cycles; dN is sampled in every one of them, including the last.
    - start is ignored.
  - HOLD:
    - valid=1; vN = pN (registered).
    - start=1 -> COLLECT, with the same load and clear as IDLE; valid and vN drop to 0 on that same edge.
    - Otherwise stay indefinitely.
- Outputs:
  - vN is 0 whenever valid=0. Downstream never sees partial votes.
  - valid and busy are never high together.
- Latency: with bN stable high from before edge k, vote pN is set at edge k+DEBOUNCE_CYCLES+2, provided the FSM is in COLLECT on that edge.
- Boundary conditions:
  - Press qualifying on the last COLLECT cycle: counted.
  - Press qualifying on the first HOLD cycle: not counted.
  - Button held across rounds: counted again in the new round, since dN is level-based.
  - start and rst together: rst wins.
  - rst mid-COLLECT: returns to IDLE with valid=0 and votes lost.
  - Button released after qualifying: vote stays set.
  - A bounce shorter than DEBOUNCE_CYCLES: never sets a vote.

Test Plan:
- Reset then idle 20 cycles, buttons toggling -> v1..v3=0, valid=0, busy=0 throughout; no state change without start.
- start pulse at cycle 0; b1 and b3 held high from cycle 2 -> busy high for exactly 16 cycles (1..16); valid rises cycle 17 with v1=1, v2=0, v3=1; valid held until next start.
- Bounce on b2 during COLLECT: high 3 cycles, low 1, high 3, low -> v2=0 at valid. Repeat with b2 high 4 clean cycles -> v2=1.
- b1 timed so d1 first asserts on the last COLLECT cycle -> v1=1. Shifted one cycle later -> v1=0.
- In HOLD with v=101, assert start while b2 held high -> same edge: valid=0, v=000, busy=1. The next round ends with v=010 (if b1/b3 released before the round) and valid=1.
- rst asserted mid-COLLECT with a vote already latched -> next edge: IDLE, all outputs 0. A subsequent start runs a full clean 16-cycle round.
